// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, reset level, logic constants and read-source encoding for wb_regfile.
package wb_regfile_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic TRUE_V = 1'b1;
  localparam logic FALSE_V = 1'b0;
  typedef enum logic [1:0] {SRC_ZERO, SRC_EX, SRC_WBQ, SRC_ARR} rd_src_e;
endpackage

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: write-back pipeline register {we, addr, data} with flush-over-stall priority.
module wb_stage_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    we_d   = flush_i ? FALSE_V : stall_i ? we_q : we_i;
    addr_d = flush_i ? '0 : stall_i ? addr_q : addr_i;
    data_d = flush_i ? '0 : stall_i ? data_q : data_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      we_q   <= FALSE_V;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register, 2^ADDR_W-entry register file (entry 0 reads 0) and two read ports.
// Define WB_REGFILE_FWD_EN to forward ex input and write-back register data to the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              wb_we_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              stall,
  input  logic              flush,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);
  localparam int DEPTH = 1 << ADDR_W;
  logic              wbq_we;
  logic [ADDR_W-1:0] wbq_addr;
  logic [DATA_W-1:0] wbq_data;
  logic [DATA_W-1:0] reg_q [DEPTH];
  logic              ex_hit1, ex_hit2, q_hit1, q_hit2;
  rd_src_e           src1, src2;
  wb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wbq (
    .clk    (clk),
    .rst    (rst),
    .stall_i(stall),
    .flush_i(flush),
    .we_i   (wb_we_i),
    .addr_i (wb_addr_i),
    .data_i (wb_data_i),
    .we_o   (wbq_we),
    .addr_o (wbq_addr),
    .data_o (wbq_data)
  );
  // Commit ignores stall/flush: a held entry simply rewrites the same value.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) reg_q[i] <= '0;
    end else if (wbq_we && wbq_addr != '0) begin
      reg_q[wbq_addr] <= wbq_data;
    end
  end
`ifdef WB_REGFILE_FWD_EN
  assign ex_hit1 = wb_we_i && wb_addr_i == raddr1;
  assign ex_hit2 = wb_we_i && wb_addr_i == raddr2;
  assign q_hit1  = wbq_we && wbq_addr == raddr1;
  assign q_hit2  = wbq_we && wbq_addr == raddr2;
`else
  assign ex_hit1 = FALSE_V;
  assign ex_hit2 = FALSE_V;
  assign q_hit1  = FALSE_V;
  assign q_hit2  = FALSE_V;
`endif
  always_comb begin
    src1   = (!re1 || raddr1 == '0) ? SRC_ZERO : ex_hit1 ? SRC_EX : q_hit1 ? SRC_WBQ : SRC_ARR;
    src2   = (!re2 || raddr2 == '0) ? SRC_ZERO : ex_hit2 ? SRC_EX : q_hit2 ? SRC_WBQ : SRC_ARR;
    rdata1 = src1 == SRC_EX ? wb_data_i : src1 == SRC_WBQ ? wbq_data : src1 == SRC_ARR ? reg_q[raddr1] : '0;
    rdata2 = src2 == SRC_EX ? wb_data_i : src2 == SRC_WBQ ? wbq_data : src2 == SRC_ARR ? reg_q[raddr2] : '0;
  end
  assign wb_we_o   = wbq_we;
  assign wb_addr_o = wbq_addr;
  assign wb_data_o = wbq_data;
endmodule
